// File: rtl/cmsdk_mcu_mtx_pkg.sv
// Shared AHB encodings and burst helpers for the CMSDK MCU bus-matrix output stages.
package cmsdk_mcu_mtx_pkg;

  localparam int BEATS_W = 5;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  // Beats remaining after the first beat; 0 for bursts of undefined length.
  function automatic logic [BEATS_W-1:0] burst_beats(input logic [2:0] hburst);
    logic [BEATS_W-1:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd15;
      default:                      beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/cmsdk_mcu_mtx_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after start_idx, wrapping.
module cmsdk_mcu_mtx_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    start_idx,
  output logic                 found,
  output logic [PORT_W-1:0]    idx
);

  logic [PORT_W:0]   sum_s;
  logic [PORT_W-1:0] cand_s;
  logic              hit_s;

  // Walk candidates in rotated order; the first hit wins and later hits are ignored.
  always_comb begin
    found  = 1'b0;
    idx    = {PORT_W{1'b0}};
    sum_s  = {(PORT_W+1){1'b0}};
    cand_s = {PORT_W{1'b0}};
    hit_s  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum_s  = {1'b0, start_idx} + (PORT_W+1)'(i);
      cand_s = (sum_s >= (PORT_W+1)'(NUM_PORTS)) ?
               PORT_W'(sum_s - (PORT_W+1)'(NUM_PORTS)) : sum_s[PORT_W-1:0];
      hit_s  = ~found & req[cand_s];
      idx    = hit_s ? cand_s : idx;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/cmsdk_mcu_mtx_rr_arb.sv
// Round-robin output-stage arbiter; holds the grant across fixed-length bursts and locks.
module cmsdk_mcu_mtx_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port
);

  import cmsdk_mcu_mtx_pkg::*;

  logic [PORT_W-1:0]  last_grant_r;
  logic [BEATS_W-1:0] beats_left_r;
  logic [BEATS_W-1:0] beats_nxt_s;
  logic [PORT_W-1:0]  start_idx_s;
  logic               burst_start_s;
  logic               hold_s;
  logic               pick_found_s;
  logic [PORT_W-1:0]  pick_idx_s;

  // Hold decision, burst beat counter next-state and round-robin start point.
  always_comb begin
    burst_start_s = HSELM & (HTRANSM == HTRANS_NONSEQ) & (burst_beats(HBURSTM) != 5'd0);
    hold_s        = ~no_port & (HMASTLOCKM | (beats_left_r != 5'd0) | burst_start_s);
    if (burst_start_s) begin
      beats_nxt_s = burst_beats(HBURSTM);
    end else if (HSELM & (HTRANSM == HTRANS_SEQ) & (beats_left_r != 5'd0)) begin
      beats_nxt_s = beats_left_r - 5'd1;
    end else if ((HTRANSM == HTRANS_IDLE) | (HTRANSM == HTRANS_NONSEQ)) begin
      beats_nxt_s = 5'd0;
    end else begin
      beats_nxt_s = beats_left_r;
    end
    if (last_grant_r == PORT_W'(NUM_PORTS - 1)) begin
      start_idx_s = {PORT_W{1'b0}};
    end else begin
      start_idx_s = last_grant_r + PORT_W'(1);
    end
  end

  cmsdk_mcu_mtx_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req       (req_port),
    .start_idx (start_idx_s),
    .found     (pick_found_s),
    .idx       (pick_idx_s)
  );

  // Arbitration state; frozen while the output stage is in a wait state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= {PORT_W{1'b0}};
      no_port      <= 1'b1;
      last_grant_r <= PORT_W'(NUM_PORTS - 1);
      beats_left_r <= 5'd0;
    end else if (HREADYM) begin
      beats_left_r <= beats_nxt_s;
      if (!hold_s) begin
        if (pick_found_s) begin
          addr_in_port <= pick_idx_s;
          no_port      <= 1'b0;
          last_grant_r <= pick_idx_s;
        end else begin
          no_port      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmsdk_mcu_mtx_rr_arb.sv
// Bench for cmsdk_mcu_mtx_rr_arb: per-cycle model comparison plus directed literal checks.
module tb_cmsdk_mcu_mtx_rr_arb;

  localparam int N = 4;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_WRAP4 = 3'd2, B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  logic         HCLK;
  logic         HRESETn;
  logic [N-1:0] req_port;
  logic         HREADYM;
  logic         HSELM;
  logic [1:0]   HTRANSM;
  logic [2:0]   HBURSTM;
  logic         HMASTLOCKM;
  logic [1:0]   addr_in_port;
  logic         no_port;

  cmsdk_mcu_mtx_rr_arb #(.NUM_PORTS(N)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: owner, last grantee and remaining beats kept as plain numbers.
  logic [1:0] m_addr, m_last;
  logic       m_none;
  logic [4:0] m_beats;
  logic       m_bstart, m_hold, m_found;
  logic [4:0] m_beats_nxt;
  int         m_len, m_pick, p;

  always_comb begin
    m_bstart = HSELM && (HTRANSM == T_NSEQ) && (HBURSTM >= 3'd2);
    m_len    = (HBURSTM >= 3'd6) ? 16 : ((HBURSTM >= 3'd4) ? 8 : 4);
    m_hold   = !m_none && (HMASTLOCKM || (m_beats > 5'd0) || m_bstart);
    if (m_bstart) m_beats_nxt = 5'(m_len - 1);
    else if (HSELM && HTRANSM == T_SEQ && m_beats > 5'd0) m_beats_nxt = m_beats - 5'd1;
    else if (HTRANSM == T_IDLE || HTRANSM == T_NSEQ) m_beats_nxt = 5'd0;
    else m_beats_nxt = m_beats;
    m_found = 1'b0;
    m_pick  = 0;
    p       = 0;
    for (int k = 1; k <= N; k++) begin
      p = (int'(m_last) + k) % N;
      if (!m_found && req_port[p[1:0]]) begin
        m_found = 1'b1;
        m_pick  = p;
      end
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_addr  <= 2'd0;
      m_none  <= 1'b1;
      m_last  <= 2'(N - 1);
      m_beats <= 5'd0;
    end else if (HREADYM) begin
      m_beats <= m_beats_nxt;
      if (!m_hold) begin
        if (m_found) begin
          m_addr <= 2'(m_pick);
          m_none <= 1'b0;
          m_last <= 2'(m_pick);
        end else begin
          m_none <= 1'b1;
        end
      end
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic       pin_en;
  logic [1:0] pin_addr;
  logic       pin_none;
  string      pin_name;

  // Single compare process on the falling edge.
  initial begin
    forever begin
      @(negedge HCLK);
      checks = checks + 1;
      if (addr_in_port !== m_addr) begin
        errors = errors + 1;
        $display("FAIL model_addr t=%0t actual=%0d expected=%0d", $time, addr_in_port, m_addr);
      end
      checks = checks + 1;
      if (no_port !== m_none) begin
        errors = errors + 1;
        $display("FAIL model_no_port t=%0t actual=%0d expected=%0d", $time, no_port, m_none);
      end
      checks = checks + 1;
      if (dut.beats_left_r !== m_beats) begin
        errors = errors + 1;
        $display("FAIL model_beats t=%0t actual=%0d expected=%0d", $time, dut.beats_left_r, m_beats);
      end
      if (pin_en) begin
        checks = checks + 1;
        if (addr_in_port !== pin_addr) begin
          errors = errors + 1;
          $display("FAIL %s addr t=%0t actual=%0d expected=%0d", pin_name, $time, addr_in_port, pin_addr);
        end
        checks = checks + 1;
        if (no_port !== pin_none) begin
          errors = errors + 1;
          $display("FAIL %s no_port t=%0t actual=%0d expected=%0d", pin_name, $time, no_port, pin_none);
        end
      end
    end
  end

  task automatic tick();
    pin_en = 1'b0;
    @(posedge HCLK);
    #1;
  endtask

  task automatic pin_out(input string name, input logic [1:0] a, input logic n);
    pin_name = name;
    pin_addr = a;
    pin_none = n;
    pin_en   = 1'b1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                       input logic lk);
    req_port   = req;
    HSELM      = 1'b1;
    HTRANSM    = tr;
    HBURSTM    = bu;
    HMASTLOCKM = lk;
  endtask

  initial begin
    HRESETn = 1'b0; req_port = 4'b0000; HREADYM = 1'b1; HSELM = 1'b0;
    HTRANSM = T_IDLE; HBURSTM = B_SINGLE; HMASTLOCKM = 1'b0; pin_en = 1'b0;
    pin_addr = 2'd0; pin_none = 1'b0; pin_name = "";
    tick(); tick();
    pin_out("reset", 2'd0, 1'b1);
    tick();
    HRESETn = 1'b1;

    // Plain round-robin with SINGLE transfers.
    drive(4'b1111, T_NSEQ, B_SINGLE, 1'b0);
    tick(); pin_out("rr_0", 2'd0, 1'b0);
    tick(); pin_out("rr_1", 2'd1, 1'b0);
    tick(); pin_out("rr_2", 2'd2, 1'b0);
    tick(); pin_out("rr_3", 2'd3, 1'b0);
    tick(); pin_out("rr_wrap", 2'd0, 1'b0);

    // Port 2 INCR8 held for 8 ready edges.
    drive(4'b0100, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("incr8_grant", 2'd2, 1'b0);
    drive(4'b1111, T_NSEQ, B_INCR8, 1'b0);
    tick(); pin_out("incr8_first", 2'd2, 1'b0);
    drive(4'b1111, T_SEQ, B_INCR8, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    pin_out("incr8_last", 2'd2, 1'b0);
    drive(4'b1111, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("incr8_next", 2'd3, 1'b0);

    // Port 1 WRAP4 with BUSY and a three-cycle wait state.
    drive(4'b0010, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("wrap4_grant", 2'd1, 1'b0);
    drive(4'b1111, T_NSEQ, B_WRAP4, 1'b0);
    tick();
    drive(4'b1111, T_SEQ, B_WRAP4, 1'b0);
    tick();
    drive(4'b1111, T_BUSY, B_WRAP4, 1'b0);
    tick(); pin_out("wrap4_busy", 2'd1, 1'b0);
    drive(4'b1111, T_SEQ, B_WRAP4, 1'b0);
    HREADYM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); pin_out("wrap4_wait", 2'd1, 1'b0);
    end
    HREADYM = 1'b1;
    tick(); tick(); pin_out("wrap4_end", 2'd1, 1'b0);
    drive(4'b1111, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("wrap4_next", 2'd2, 1'b0);

    // Port 0 INCR16 terminated early after beat 5.
    drive(4'b0001, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("incr16_grant", 2'd0, 1'b0);
    drive(4'b0011, T_NSEQ, B_INCR16, 1'b0);
    tick();
    drive(4'b0011, T_SEQ, B_INCR16, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    drive(4'b0011, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("early_term_clear", 2'd0, 1'b0);
    tick(); pin_out("early_term_next", 2'd1, 1'b0);

    // Port 3 locked while its request drops.
    drive(4'b1000, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("lock_grant", 2'd3, 1'b0);
    drive(4'b0000, T_NSEQ, B_SINGLE, 1'b1);
    tick(); pin_out("lock_hold_a", 2'd3, 1'b0);
    tick(); pin_out("lock_hold_b", 2'd3, 1'b0);
    drive(4'b0000, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("lock_release", 2'd3, 1'b1);

    // Reset asserted mid-INCR8 on port 2.
    drive(4'b0100, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("rst_burst_grant", 2'd2, 1'b0);
    drive(4'b0100, T_NSEQ, B_INCR8, 1'b0);
    tick();
    drive(4'b0100, T_SEQ, B_INCR8, 1'b0);
    tick(); tick();
    HRESETn = 1'b0;
    pin_out("reset_mid_burst", 2'd0, 1'b1);
    tick(); tick();
    HRESETn = 1'b1;
    drive(4'b0001, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("post_reset", 2'd0, 1'b0);

    // Lock rising with a WRAP4 start; release of the lock alone does not end the hold.
    drive(4'b1111, T_NSEQ, B_WRAP4, 1'b1);
    tick(); pin_out("lock_burst_start", 2'd0, 1'b0);
    drive(4'b1111, T_SEQ, B_WRAP4, 1'b0);
    tick(); tick(); tick(); pin_out("lock_burst_tail", 2'd0, 1'b0);
    drive(4'b1111, T_IDLE, B_SINGLE, 1'b0);
    tick(); pin_out("lock_burst_next", 2'd1, 1'b0);

    tick();
    @(negedge HCLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
